fetch: RTL and testbench

Instruction fetch stage: sits directly upstream of the decode stage. Reads 16-bit words from instruction memory over a single-outstanding req/ack port, assembles each instruction plus its optional 16-bit extension word, and presents `ins`/`ext` with a one-cycle `ins_en` strobe. Also tracks the fetch PC, honours a back-end stall, and redirects to a new PC on branch/jump resolution.

---
 rtl/fetch_pkg.sv | 32 +++
 rtl/fetch_pc.sv | 43 ++++
 rtl/fetch.sv | 138 +++++++++++++
 tb/tb_fetch.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch/decode definitions: opcode extraction, fetch FSM states and the
// buffered-instruction payload.
package fetch_pkg;

   localparam int unsigned WORD_W   = 16;
   localparam int unsigned OPCODE_W = 4;

   localparam logic [OPCODE_W-1:0] OPCODE_JMPIMM    = 4'hC;
   localparam logic [WORD_W-1:0]   RESET_PC_DEFAULT = 16'h0000;

   typedef enum logic [1:0] {
      S_INS  = 2'd0,
      S_EXT  = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   typedef struct packed {
      logic [WORD_W-1:0] ins;
      logic [WORD_W-1:0] ext;
      logic [WORD_W-1:0] pc;
   } insn_t;

   // Opcode field as seen by both fetch and decode.
   function automatic logic [OPCODE_W-1:0] opcode_of(input logic [WORD_W-1:0] word);
      return word[WORD_W-1 -: OPCODE_W];
   endfunction

   function automatic logic needs_ext(input logic [OPCODE_W-1:0] opcode);
      return opcode == OPCODE_JMPIMM;
   endfunction

endpackage

// File: rtl/fetch_pc.sv
// Fetch PC bookkeeping: current pc, and the pending-redirect target used while
// an in-flight memory request is drained and its data discarded.
module fetch_pc
   import fetch_pkg::*;
#(
   parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              redirect,
   input  logic [WORD_W-1:0] redirect_pc,
   input  logic              busy,
   input  logic              ack,
   input  logic              advance,
   input  logic [WORD_W-1:0] next_pc,
   output logic [WORD_W-1:0] pc,
   output logic [WORD_W-1:0] target,
   output logic              discard
);

   // Redirect outranks everything; a busy port defers the jump until its ack.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc      <= RESET_PC;
         target  <= RESET_PC;
         discard <= 1'b0;
      end else if (redirect) begin
         if (busy) begin
            discard <= 1'b1;
            target  <= redirect_pc;
         end else begin
            pc      <= redirect_pc;
            discard <= 1'b0;
         end
      end else if (discard && ack) begin
         pc      <= target;
         discard <= 1'b0;
      end else if (advance) begin
         pc <= next_pc;
      end
   end

endmodule

// File: rtl/fetch.sv
// Instruction fetch stage: single-outstanding imem port, optional extension
// word assembly, stall hold buffer and redirect handling.
module fetch
   import fetch_pkg::*;
#(
   parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic              cpu_clk,
   input  logic              cpu_rst,
   output logic              imem_req,
   output logic [WORD_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [WORD_W-1:0] imem_data,
   input  logic              stall,
   input  logic              redirect,
   input  logic [WORD_W-1:0] redirect_pc,
   output logic [WORD_W-1:0] ins,
   output logic [WORD_W-1:0] ext,
   output logic              ins_en,
   output logic [WORD_W-1:0] ins_pc
);

   state_t            state;
   insn_t             hold_buf;
   insn_t             cur_c;
   logic [WORD_W-1:0] pc;
   logic [WORD_W-1:0] target;
   logic [WORD_W-1:0] next_pc_c;
   logic              discard;
   logic              ack_c;
   logic              busy_c;
   logic              complete_c;

   assign ack_c      = imem_req & imem_ack;
   assign busy_c     = imem_req & ~imem_ack;
   assign complete_c = ack_c & ~redirect & ~discard &
                       ((state == S_EXT) |
                        ((state == S_INS) & ~needs_ext(opcode_of(imem_data))));
   assign next_pc_c  = pc + ((state == S_EXT) ? WORD_W'(2) : WORD_W'(1));

   // Instruction being completed this cycle.
   always_comb begin
      cur_c    = '0;
      cur_c.pc = pc;
      if (state == S_EXT) begin
         cur_c.ins = hold_buf.ins;
         cur_c.ext = imem_data;
      end else begin
         cur_c.ins = imem_data;
      end
   end

   fetch_pc #(
      .RESET_PC (RESET_PC)
   ) u_pc (
      .clk         (cpu_clk),
      .rst         (cpu_rst),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .busy        (busy_c),
      .ack         (ack_c),
      .advance     (complete_c),
      .next_pc     (next_pc_c),
      .pc          (pc),
      .target      (target),
      .discard     (discard)
   );

   always_ff @(posedge cpu_clk) begin
      if (cpu_rst) begin
         state     <= S_INS;
         imem_req  <= 1'b0;
         imem_addr <= RESET_PC;
         ins       <= '0;
         ext       <= '0;
         ins_pc    <= '0;
         ins_en    <= 1'b0;
         hold_buf  <= '0;
      end else begin
         ins_en <= 1'b0;
         if (redirect) begin
            // A busy port keeps its address until ack; the data is then dropped.
            state <= S_INS;
            if (!busy_c) begin
               imem_req  <= 1'b1;
               imem_addr <= redirect_pc;
            end
         end else if (discard) begin
            if (ack_c) begin
               state     <= S_INS;
               imem_req  <= 1'b1;
               imem_addr <= target;
            end
         end else if (complete_c) begin
            imem_addr <= next_pc_c;
            if (stall) begin
               state    <= S_HOLD;
               imem_req <= 1'b0;
               hold_buf <= cur_c;
            end else begin
               state    <= S_INS;
               imem_req <= 1'b1;
               ins      <= cur_c.ins;
               ext      <= cur_c.ext;
               ins_pc   <= cur_c.pc;
               ins_en   <= 1'b1;
            end
         end else begin
            case (state)
               S_INS: begin
                  imem_req <= 1'b1;
                  if (ack_c) begin
                     hold_buf.ins <= imem_data;
                     imem_addr    <= pc + WORD_W'(1);
                     state        <= S_EXT;
                  end else begin
                     imem_addr <= pc;
                  end
               end
               S_EXT: ;
               S_HOLD: begin
                  if (!stall) begin
                     state     <= S_INS;
                     imem_req  <= 1'b1;
                     imem_addr <= pc;
                     ins       <= hold_buf.ins;
                     ext       <= hold_buf.ext;
                     ins_pc    <= hold_buf.pc;
                     ins_en    <= 1'b1;
                  end
               end
               default: state <= S_INS;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch: per-cycle vector table driving memory/stall/redirect
// and checking outputs, plus hand sequences for wrap, redirect overwrite and reset.
module tb_fetch;
   import fetch_pkg::*;

   logic        cpu_clk;
   logic        cpu_rst;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ack;
   logic [15:0] imem_data;
   logic        stall;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic [15:0] ins;
   logic [15:0] ext;
   logic        ins_en;
   logic [15:0] ins_pc;

   int total = 0;
   int bad   = 0;

   localparam logic [15:0] JMP = {OPCODE_JMPIMM, 12'h123};

   fetch #(.RESET_PC(16'h0000)) dut (
      .cpu_clk     (cpu_clk),
      .cpu_rst     (cpu_rst),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_data   (imem_data),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .ins         (ins),
      .ext         (ext),
      .ins_en      (ins_en),
      .ins_pc      (ins_pc)
   );

   initial cpu_clk = 1'b0;
   always #5 cpu_clk = ~cpu_clk;

   // Inputs applied during a cycle, and outputs expected during that same cycle.
   typedef struct {
      logic        st;
      logic        rd;
      logic [15:0] rpc;
      logic        ak;
      logic [15:0] dat;
      logic        ereq;
      logic [15:0] eaddr;
      logic        een;
      logic [15:0] eins;
      logic [15:0] eext;
      logic [15:0] epc;
   } vec_t;

   vec_t tbl [21];

   function automatic vec_t v(input logic st, input logic rd, input logic [15:0] rpc,
                              input logic ak, input logic [15:0] dat, input logic ereq,
                              input logic [15:0] eaddr, input logic een,
                              input logic [15:0] eins, input logic [15:0] eext,
                              input logic [15:0] epc);
      vec_t r;
      r.st = st; r.rd = rd; r.rpc = rpc; r.ak = ak; r.dat = dat;
      r.ereq = ereq; r.eaddr = eaddr; r.een = een;
      r.eins = eins; r.eext = eext; r.epc = epc;
      return r;
   endfunction

   task automatic chk(input string tag, input string field, input logic [15:0] act,
                      input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s.%s got=%h want=%h", tag, field, act, exp);
      end
   endtask

   // Called at a negedge: check current outputs, drive inputs, advance one cycle.
   task automatic run_vec(input string tag, input vec_t x);
      chk(tag, "req",  16'(imem_req), 16'(x.ereq));
      chk(tag, "addr", imem_addr, x.eaddr);
      chk(tag, "en",   16'(ins_en), 16'(x.een));
      if (x.een) begin
         chk(tag, "ins",    ins,    x.eins);
         chk(tag, "ext",    ext,    x.eext);
         chk(tag, "ins_pc", ins_pc, x.epc);
      end
      stall       = x.st;
      redirect    = x.rd;
      redirect_pc = x.rpc;
      imem_ack    = x.ak;
      imem_data   = x.dat;
      @(negedge cpu_clk);
   endtask

   task automatic chk_reset(input string tag);
      chk(tag, "req",    16'(imem_req), 16'h0000);
      chk(tag, "addr",   imem_addr,     16'h0000);
      chk(tag, "en",     16'(ins_en),   16'h0000);
      chk(tag, "ins",    ins,           16'h0000);
      chk(tag, "ext",    ext,           16'h0000);
      chk(tag, "ins_pc", ins_pc,        16'h0000);
   endtask

   initial begin
      //               st rd rpc       ak dat       req addr      en ins       ext       pc
      tbl[0]  = v(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000);
      tbl[1]  = v(0, 0, 16'h0000, 1, 16'h1111, 1, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000);
      tbl[2]  = v(0, 0, 16'h0000, 1, 16'h2222, 1, 16'h0001, 1, 16'h1111, 16'h0000, 16'h0000);
      tbl[3]  = v(0, 0, 16'h0000, 1, 16'h3333, 1, 16'h0002, 1, 16'h2222, 16'h0000, 16'h0001);
      tbl[4]  = v(0, 1, 16'h0010, 0, 16'h0000, 1, 16'h0003, 1, 16'h3333, 16'h0000, 16'h0002);
      tbl[5]  = v(0, 0, 16'h0000, 1, 16'h4444, 1, 16'h0003, 0, 16'h0000, 16'h0000, 16'h0000);
      tbl[6]  = v(0, 0, 16'h0000, 1, JMP,      1, 16'h0010, 0, 16'h0000, 16'h0000, 16'h0000);
      tbl[7]  = v(0, 0, 16'h0000, 1, 16'hBEEF, 1, 16'h0011, 0, 16'h0000, 16'h0000, 16'h0000);
      tbl[8]  = v(1, 0, 16'h0000, 1, 16'h5555, 1, 16'h0012, 1, JMP,      16'hBEEF, 16'h0010);
      tbl[9]  = v(1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0013, 0, 16'h0000, 16'h0000, 16'h0000);
      tbl[10] = v(1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0013, 0, 16'h0000, 16'h0000, 16'h0000);
      tbl[11] = v(1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0013, 0, 16'h0000, 16'h0000, 16'h0000);
      tbl[12] = v(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0013, 0, 16'h0000, 16'h0000, 16'h0000);
      tbl[13] = v(0, 0, 16'h0000, 1, 16'h6666, 1, 16'h0013, 1, 16'h5555, 16'h0000, 16'h0012);
      tbl[14] = v(0, 1, 16'h0005, 1, 16'h7777, 1, 16'h0014, 1, 16'h6666, 16'h0000, 16'h0013);
      tbl[15] = v(0, 1, 16'h0100, 0, 16'h0000, 1, 16'h0005, 0, 16'h0000, 16'h0000, 16'h0000);
      tbl[16] = v(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0005, 0, 16'h0000, 16'h0000, 16'h0000);
      tbl[17] = v(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0005, 0, 16'h0000, 16'h0000, 16'h0000);
      tbl[18] = v(0, 0, 16'h0000, 1, 16'h8888, 1, 16'h0005, 0, 16'h0000, 16'h0000, 16'h0000);
      tbl[19] = v(0, 0, 16'h0000, 1, 16'h9999, 1, 16'h0100, 0, 16'h0000, 16'h0000, 16'h0000);
      tbl[20] = v(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0101, 1, 16'h9999, 16'h0000, 16'h0100);

      cpu_rst     = 1'b1;
      imem_ack    = 1'b0;
      imem_data   = 16'h0000;
      stall       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 16'h0000;
      repeat (2) @(negedge cpu_clk);
      chk_reset("rst0");
      cpu_rst = 1'b0;

      for (int i = 0; i < 21; i++) run_vec($sformatf("t%0d", i), tbl[i]);

      // Fresh reset, then JMPIMM at 0xFFFF wrapping, and a redirect overwritten mid-drain.
      cpu_rst = 1'b1;
      @(negedge cpu_clk);
      chk_reset("rst1");
      cpu_rst = 1'b0;
      run_vec("w0", v(0, 1, 16'hFFFF, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000));
      run_vec("w1", v(0, 0, 16'h0000, 1, JMP,      1, 16'hFFFF, 0, 16'h0000, 16'h0000, 16'h0000));
      run_vec("w2", v(0, 0, 16'h0000, 1, 16'h1234, 1, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000));
      run_vec("w3", v(0, 1, 16'h0100, 0, 16'h0000, 1, 16'h0001, 1, JMP,      16'h1234, 16'hFFFF));
      run_vec("w4", v(0, 1, 16'h0300, 0, 16'h0000, 1, 16'h0001, 0, 16'h0000, 16'h0000, 16'h0000));
      run_vec("w5", v(0, 0, 16'h0000, 1, 16'h1111, 1, 16'h0001, 0, 16'h0000, 16'h0000, 16'h0000));
      run_vec("w6", v(0, 0, 16'h0000, 1, 16'h2222, 1, 16'h0300, 0, 16'h0000, 16'h0000, 16'h0000));
      run_vec("w7", v(0, 0, 16'h0000, 1, JMP,      1, 16'h0301, 1, 16'h2222, 16'h0000, 16'h0300));

      // Reset while waiting on the extension word, with an ack that must be ignored.
      chk("x0", "req",  16'(imem_req), 16'h0001);
      chk("x0", "addr", imem_addr,     16'h0302);
      cpu_rst   = 1'b1;
      imem_ack  = 1'b1;
      imem_data = 16'h4444;
      @(negedge cpu_clk);
      chk_reset("rst2");
      cpu_rst   = 1'b0;
      imem_ack  = 1'b0;
      imem_data = 16'h0000;
      run_vec("r0", v(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000));
      run_vec("r1", v(0, 0, 16'h0000, 1, 16'h1111, 1, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000));
      run_vec("r2", v(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0001, 1, 16'h1111, 16'h0000, 16'h0000));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
